// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA receive-side pixel timing recovery, frame statistics and timing checks
// Optional FRAME_CRC_EN adds frame_crc, a CRC-16-CCITT over the active pixels of each frame.
module vga_frame_monitor #(
   parameter int CLK_DIV  = 4,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int SYNC_ACT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  rgb,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [2:0]  pix_rgb,
   output logic        frame_done,
   output logic [18:0] lit_count,
   output logic        locked,
   output logic        h_err,
`ifdef FRAME_CRC_EN
   output logic        v_err,
   output logic [15:0] frame_crc
`else
   output logic        v_err
`endif
);

   localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_SAMP = PW'(CLK_DIV / 2);
   localparam logic [9:0]    H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0]    H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0]    H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [9:0]    V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0]    V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [9:0]    V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
   localparam logic [9:0]    CNT_MAX = 10'h3FF;
   localparam logic [18:0]   LIT_MAX = 19'h7FFFF;
   localparam logic          ACT     = (SYNC_ACT != 0);

   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          hs_q, vs_q, hs_prev_q, vs_prev_q;
   logic [2:0]    rgb_q;
   logic [PW-1:0] phase_q, phase_d;
   logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic          first_q;
   logic [18:0]   acc_q, acc_d, lit_q;
   logic          pix_valid_q, frame_done_q, h_err_q, h_err_d, v_err_q, v_err_d;
   logic [9:0]    pix_x_q, pix_y_q;
   logic [2:0]    pix_rgb_q;
   logic          hs_edge, vs_edge, tracking, ph_wrap, sample_act, frame_end, h_fail, v_fail;

   always_comb begin
      hs_edge    = (hs_q == ACT) && (hs_prev_q != ACT);
      vs_edge    = (vs_q == ACT) && (vs_prev_q != ACT);
      tracking   = (state_q != SEARCH);
      ph_wrap    = (phase_q == PH_LAST);
      sample_act = tracking && (phase_q == PH_SAMP) &&
                   (hcnt_q >= H_START) && (hcnt_q <= H_END) &&
                   (vcnt_q >= V_START) && (vcnt_q <= V_END);
      frame_end  = tracking && vs_edge;
      // The first hsync after leaving SEARCH follows an unknown partial line.
      h_fail     = tracking && ((hs_edge && !first_q && (hcnt_q != H_LAST)) || (hcnt_q == CNT_MAX));
      v_fail     = tracking && ((vs_edge && (vcnt_q != V_LAST)) || (vcnt_q == CNT_MAX));
      // Errors stay visible during the frame_done cycle and clear on the one after.
      h_err_d    = (h_err_q && !frame_done_q) || h_fail;
      v_err_d    = (v_err_q && !frame_done_q) || v_fail;

      state_d = state_q;
      case (state_q)
         SEARCH:        if (vs_edge) state_d = TRACK;
         TRACK, LOCKED: if (vs_edge) state_d = (h_err_d || v_err_d) ? TRACK : LOCKED;
         default:       state_d = SEARCH;
      endcase

      if (hs_edge) begin
         phase_d = '0;
         hcnt_d  = '0;
      end else begin
         phase_d = ph_wrap ? '0 : phase_q + 1'b1;
         hcnt_d  = (ph_wrap && (hcnt_q != CNT_MAX)) ? hcnt_q + 10'd1 : hcnt_q;
      end

      if (vs_edge)
         vcnt_d = '0;
      else if (hs_edge && (vcnt_q != CNT_MAX))
         vcnt_d = vcnt_q + 10'd1;
      else
         vcnt_d = vcnt_q;

      if (!tracking || frame_end)
         acc_d = '0;
      else if (sample_act && (rgb_q != 3'd0) && (acc_q != LIT_MAX))
         acc_d = acc_q + 19'd1;
      else
         acc_d = acc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SEARCH;
         hs_q         <= ~ACT;
         vs_q         <= ~ACT;
         hs_prev_q    <= ~ACT;
         vs_prev_q    <= ~ACT;
         rgb_q        <= '0;
         phase_q      <= '0;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         first_q      <= 1'b1;
         acc_q        <= '0;
         lit_q        <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_rgb_q    <= '0;
         frame_done_q <= 1'b0;
         h_err_q      <= 1'b0;
         v_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hs_q         <= hsync;
         vs_q         <= vsync;
         hs_prev_q    <= hs_q;
         vs_prev_q    <= vs_q;
         rgb_q        <= rgb;
         phase_q      <= phase_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         first_q      <= (state_q == SEARCH) ? 1'b1 : (first_q && !hs_edge);
         acc_q        <= acc_d;
         pix_valid_q  <= sample_act;
         frame_done_q <= frame_end;
         h_err_q      <= h_err_d;
         v_err_q      <= v_err_d;
         if (sample_act) begin
            pix_x_q   <= hcnt_q - H_START;
            pix_y_q   <= vcnt_q - V_START;
            pix_rgb_q <= rgb_q;
         end
         if (frame_end)
            lit_q <= acc_q;
      end
   end

`ifdef FRAME_CRC_EN
   logic [15:0] crc_q, frame_crc_q;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 2; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q       <= 16'hFFFF;
         frame_crc_q <= 16'h0000;
      end else begin
         if (!tracking || frame_end)
            crc_q <= 16'hFFFF;
         else if (pix_valid_q)
            crc_q <= crc_step(crc_q, pix_rgb_q);
         if (frame_end)
            frame_crc_q <= crc_q;
      end
   end

   assign frame_crc = frame_crc_q;
`endif

   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_rgb    = pix_rgb_q;
   assign frame_done = frame_done_q;
   assign lit_count  = lit_q;
   assign locked     = (state_q == LOCKED);
   assign h_err      = h_err_q;
   assign v_err      = v_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - table-driven frame scenarios with a pixel/frame scoreboard for vga_frame_monitor
// Runs with a scaled-down raster (16x12 total, 8x6 active) so whole frames fit in a short run.
module tb_vga_frame_monitor;

   localparam int CLK_DIV  = 4;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 2;
   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam int V_ACTIVE = 6;
   localparam int V_FP     = 2;
   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int SX = 5;
   localparam int SY = 3;
   localparam int NV = 12;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic [2:0]  rgb = 3'd0;
   logic        pix_valid, frame_done, locked, h_err, v_err;
   logic [9:0]  pix_x, pix_y;
   logic [2:0]  pix_rgb;
   logic [18:0] lit_count;
`ifdef FRAME_CRC_EN
   logic [15:0] frame_crc;
`endif

   vga_frame_monitor #(
      .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .SYNC_ACT(0)
   ) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_done(frame_done), .lit_count(lit_count), .locked(locked), .h_err(h_err),
`ifdef FRAME_CRC_EN
      .v_err(v_err), .frame_crc(frame_crc)
`else
      .v_err(v_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [9:0] x; logic [9:0] y; logic [2:0] c;} px_t;
   typedef struct packed {logic [18:0] lit; logic h; logic v; logic lk; logic [15:0] crc;} fd_t;
   typedef struct {int nl; int short_l; int stuck_l; int mode; bit eh; bit ev; bit el;} vec_t;

   px_t  px_q[$];
   fd_t  fd_q[$];
   vec_t tv[NV];
   int   errors = 0;
   int   checks = 0;
   logic fd_prev = 1'b0;
   px_t  mon_px;
   fd_t  mon_fd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [2:0] d);
      int v;
      v = int'(c);
      for (int i = 2; i >= 0; i--) begin
         v = v << 1;
         if (((v >> 16) & 1) != ((int'(d) >> i) & 1))
            v = v ^ 32'h1021;
         v = v & 32'hFFFF;
      end
      return 16'(v);
   endfunction

   function automatic logic [2:0] pick(input int mode, input int x, input int y);
      case (mode)
         0:       return 3'd0;
         1:       return (x == SX && y == SY) ? 3'd7 : 3'd0;
         2:       return 3'd7;
         default: return 3'($urandom_range(0, 7));
      endcase
   endfunction

   task automatic drive_px(input logic h, input logic v, input logic [2:0] c);
      hsync = h;
      vsync = v;
      rgb   = c;
      repeat (CLK_DIV) @(posedge clk);
      #1;
   endtask

   task automatic send_lines(input int first, input int last, input int short_l, input int stuck_l,
                             input int mode, input bit track, output int lit, output logic [15:0] crc);
      int         len, x, y;
      bit         stop;
      logic       vs_l;
      logic [2:0] c;
      lit  = 0;
      crc  = 16'hFFFF;
      stop = 1'b0;
      for (int l = first; l < last && !stop; l++) begin
         vs_l = (l < V_SYNC) ? 1'b0 : 1'b1;
         if (l == stuck_l) begin
            for (int i = 0; i < 1100; i++) begin
               if (i == 500) chk("hsat_before", 64'(h_err), 64'd0);
               drive_px(1'b1, vs_l, 3'($urandom_range(0, 7)));
            end
            chk("hsat_after", 64'(h_err), 64'd1);
            stop = 1'b1;
         end else begin
            len = (l == short_l) ? H_TOTAL - 1 : H_TOTAL;
            for (int p = 0; p < len; p++) begin
               x = p - (H_SYNC + H_BP);
               y = l - (V_SYNC + V_BP);
               if (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE) begin
                  c = pick(mode, x, y);
                  if (track) begin
                     px_q.push_back({10'(x), 10'(y), c});
                     if (c != 3'd0) lit++;
                     crc = crc_model(crc, c);
                  end
               end else begin
                  c = 3'($urandom_range(0, 7));
               end
               drive_px((p < H_SYNC) ? 1'b0 : 1'b1, vs_l, c);
            end
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
      chk({tag, "_pix_xyrgb"}, 64'({pix_x, pix_y, pix_rgb}), 64'd0);
      chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      chk({tag, "_lit_count"}, 64'(lit_count), 64'd0);
      chk({tag, "_locked"}, 64'(locked), 64'd0);
      chk({tag, "_errs"}, 64'({h_err, v_err}), 64'd0);
`ifdef FRAME_CRC_EN
      chk({tag, "_frame_crc"}, 64'(frame_crc), 64'd0);
`endif
   endtask

   always @(negedge clk) begin
      if (reset) begin
         fd_prev <= 1'b0;
      end else begin
         if (fd_prev) chk("err_clear", 64'({h_err, v_err}), 64'd0);
         if (pix_valid) begin
            if (px_q.size() == 0) begin
               chk("pix_unexpected", 64'd1, 64'd0);
            end else begin
               mon_px = px_q.pop_front();
               chk("pixel", 64'({pix_x, pix_y, pix_rgb}), 64'(mon_px));
            end
         end
         if (frame_done) begin
            if (fd_q.size() == 0) begin
               chk("fd_unexpected", 64'd1, 64'd0);
            end else begin
               mon_fd = fd_q.pop_front();
               chk("lit_count", 64'(lit_count), 64'(mon_fd.lit));
               chk("h_err", 64'(h_err), 64'(mon_fd.h));
               chk("v_err", 64'(v_err), 64'(mon_fd.v));
               chk("locked", 64'(locked), 64'(mon_fd.lk));
               chk("pix_count", 64'(px_q.size()), 64'd0);
`ifdef FRAME_CRC_EN
               chk("frame_crc", 64'(frame_crc), 64'(mon_fd.crc));
`endif
            end
         end
         fd_prev <= frame_done;
      end
   end

   initial begin
      int          lit;
      logic [15:0] crc;

      tv[0]  = '{12, -1, -1, 0, 1'b0, 1'b0, 1'b1};
      tv[1]  = '{12, -1, -1, 0, 1'b0, 1'b0, 1'b1};
      tv[2]  = '{12, -1, -1, 1, 1'b0, 1'b0, 1'b1};
      tv[3]  = '{12, -1, -1, 2, 1'b0, 1'b0, 1'b1};
      tv[4]  = '{12, -1, -1, 3, 1'b0, 1'b0, 1'b1};
      tv[5]  = '{12,  5, -1, 3, 1'b1, 1'b0, 1'b0};
      tv[6]  = '{12, -1, -1, 3, 1'b0, 1'b0, 1'b1};
      tv[7]  = '{12, -1, -1, 0, 1'b0, 1'b0, 1'b1};
      tv[8]  = '{11, -1, -1, 3, 1'b0, 1'b1, 1'b0};
      tv[9]  = '{12, -1, -1, 3, 1'b0, 1'b0, 1'b1};
      tv[10] = '{12, -1,  3, 0, 1'b1, 1'b1, 1'b0};
      tv[11] = '{12, -1, -1, 3, 1'b0, 1'b0, 1'b1};

      repeat (5) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;

      for (int f = 0; f < NV; f++) begin
         send_lines(0, tv[f].nl, tv[f].short_l, tv[f].stuck_l, tv[f].mode, 1'b1, lit, crc);
         fd_q.push_back({19'(lit), tv[f].eh, tv[f].ev, tv[f].el, crc});
      end

      // Mid-frame reset while locked: partial frame must never report.
      send_lines(0, 7, -1, -1, 3, 1'b1, lit, crc);
      chk("locked_before_reset", 64'(locked), 64'd1);
      chk("pix_drained", 64'(px_q.size()), 64'd0);
      reset = 1'b1;
      hsync = 1'b0;
      vsync = 1'b1;
      rgb   = 3'd5;
      @(posedge clk);
      #1;
      chk_all_zero("midreset");
      px_q.delete();
      repeat (CLK_DIV - 1) @(posedge clk);
      #1;
      reset = 1'b0;
      send_lines(8, V_TOTAL, -1, -1, 3, 1'b0, lit, crc);
      chk("search_unlocked", 64'(locked), 64'd0);

      send_lines(0, V_TOTAL, -1, -1, 3, 1'b1, lit, crc);
      chk("track_unlocked", 64'(locked), 64'd0);
      fd_q.push_back({19'(lit), 1'b0, 1'b0, 1'b1, crc});
      send_lines(0, 3, -1, -1, 0, 1'b1, lit, crc);

      repeat (60) @(posedge clk);
      #1;
      chk("fd_pending", 64'(fd_q.size()), 64'd0);
      chk("px_pending", 64'(px_q.size()), 64'd0);
      chk("relocked", 64'(locked), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
